morse_key_decoder: RTL and testbench
====================================

# morse_key_decoder

Receive-side counterpart to the game's timing chain. It samples the player's Morse key, measures press and release durations in 1 ms ticks, and classifies each press as dot or dash. When an inter-character gap elapses it emits the assembled character (pattern plus symbol count) as a one-cycle strobe. The game FSM compares that output against the ROM entry.

## Interface
- DASH_MS, 300: press length in ms at or above which a symbol is a dash; shorter is a dot.
- MIN_MS, 20: presses shorter than this are glitches and are discarded.
- GAP_MS, 700: key-up time in ms that terminates a character.
- CNT_W, 11: duration counter width; must hold GAP_MS.
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high; one clock domain.
- enable  input  1  decoder active; low forces idle.
- ms_tick  input  1  one-cycle pulse every 1 ms (from OnemsTimer_lfsr).
- key  input  1  debounced key level, asynchronous to clk; 1 = pressed.
- code  output  5  last emitted pattern, right-justified, 1 = dash; most recent symbol is in bit 0.
- len  output  3  number of valid symbols in code (0-5).
- code_valid  output  1  one-cycle strobe; code/len/code_err are updated in the same cycle.
- code_err  output  1  character exceeded 5 symbols; held with code.

## Operation
- key passes through a 2-FF synchronizer to key_s; edges are detected on key_s against its prior value.
- Internal registers: state (IDLE, PRESS, GAP), cnt[CNT_W], sr[4:0], n[2:0], ovf.
- cnt increments on ms_tick in PRESS and GAP, saturates at all-ones, and clears on every state entry.
- IDLE: sr=0, n=0, ovf=0. A rise on key_s moves to PRESS.
- PRESS, on a fall of key_s:
  - cnt < MIN_MS: discard the press and return to GAP if n>0, otherwise IDLE. The GAP cnt restarts at 0.
  - else symbol = (cnt >= DASH_MS). If n<5: sr <= {sr[3:0],symbol}, n <= n+1. If n==5: sr and n unchanged, ovf <= 1. Go to GAP.
- GAP:
  - A rise on key_s moves to PRESS. This has priority over gap expiry in the same cycle.
  - Otherwise, when cnt == GAP_MS: code<=sr, len<=n, code_err<=ovf, code_valid=1, then go to IDLE.
- enable low: synchronous return to IDLE; cnt, sr, n, and ovf are cleared; code_valid=0; code, len, and code_err hold. The synchronizer keeps running.
- code, len, and code_err change only on an emit or on reset.

## Timing
- Reset values: code=0, len=0, code_valid=0, code_err=0, state=IDLE, all internal registers 0.
- Key to key_s latency: 2 cycles. The state transition happens in the cycle key_s first differs from its previous value.
- Press classification uses the cnt value registered in the fall-detect cycle. A ms_tick in that same cycle is not counted.
- code_valid asserts exactly 1 cycle, in the cycle after the cycle in which cnt becomes GAP_MS. It is never asserted for two consecutive cycles.
- Duration resolution is ±1 ms, because the phase of ms_tick relative to the edge is arbitrary.
- rst mid-character drops the character with no strobe.
- enable falling in the same cycle as an emit: enable wins and no strobe is produced.

## Test plan
- Bench parameters: DASH_MS=3, MIN_MS=1, GAP_MS=7, ms_tick every 4 clk.
- Reset sequence: hold rst with key toggling -> all outputs 0. Release rst with key=0 for 20 ticks -> no code_valid.
- Single press of 5 ticks, then release for 7 ticks -> one code_valid with code=5'b00001, len=1, code_err=0.
- Presses of 1, 4, 1 ticks with 2-tick gaps ("R" = .-.), then idle -> code=5'b00010, len=3, exactly one strobe.
- Six dot presses, then gap -> code=5'b00000, len=5, code_err=1. The following valid character ("T") -> code_err=0.
- Glitch and priority: a 0-tick press is ignored, giving len=0 and no strobe from IDLE. A key rise in the same cycle cnt reaches GAP_MS -> no strobe, and the symbol is appended to the same character.
- enable dropped during PRESS with 2 symbols buffered -> no strobe; prior code/len held. After re-enable, a fresh character decodes correctly.

Source files
------------

// File: rtl/morse_key_decoder.sv
// Morse key decoder: times key presses/releases in ms ticks, classifies dot/dash,
// and strobes out the assembled character once the inter-character gap expires.
module morse_key_decoder #(
  parameter int DASH_MS = 300,
  parameter int MIN_MS  = 20,
  parameter int GAP_MS  = 700,
  parameter int CNT_W   = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       ms_tick,
  input  logic       key,
  output logic [4:0] code,
  output logic [2:0] len,
  output logic       code_valid,
  output logic       code_err
);

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP} state_t;

  localparam logic [CNT_W-1:0] L_DASH = CNT_W'(DASH_MS);
  localparam logic [CNT_W-1:0] L_MIN  = CNT_W'(MIN_MS);
  localparam logic [CNT_W-1:0] L_GAP  = CNT_W'(GAP_MS);

  state_t           r_state;
  logic             r_key_meta;
  logic             r_key_s;
  logic             r_key_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_sr;
  logic [2:0]       r_n;
  logic             r_ovf;

  logic             w_rise;
  logic             w_fall;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_rise    = r_key_s & ~r_key_prev;
  assign w_fall    = ~r_key_s & r_key_prev;
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  // Synchronizer runs regardless of enable so edges stay coherent across re-enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_meta <= 1'b0;
      r_key_s    <= 1'b0;
      r_key_prev <= 1'b0;
    end else begin
      r_key_meta <= key;
      r_key_s    <= r_key_meta;
      r_key_prev <= r_key_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_sr       <= '0;
      r_n        <= '0;
      r_ovf      <= 1'b0;
      code       <= '0;
      len        <= '0;
      code_valid <= 1'b0;
      code_err   <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      if (!enable) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_sr    <= '0;
        r_n     <= '0;
        r_ovf   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_cnt <= '0;
            r_sr  <= '0;
            r_n   <= '0;
            r_ovf <= 1'b0;
            if (w_rise) r_state <= S_PRESS;
          end
          S_PRESS: begin
            if (w_fall) begin
              r_cnt <= '0;
              if (r_cnt < L_MIN) begin
                r_state <= (r_n != 3'd0) ? S_GAP : S_IDLE;
              end else begin
                if (r_n < 3'd5) begin
                  r_sr <= {r_sr[3:0], (r_cnt >= L_DASH)};
                  r_n  <= r_n + 3'd1;
                end else begin
                  r_ovf <= 1'b1;
                end
                r_state <= S_GAP;
              end
            end else if (ms_tick) begin
              r_cnt <= w_cnt_inc;
            end
          end
          S_GAP: begin
            // A new press beats gap expiry so the symbol joins the same character.
            if (w_rise) begin
              r_state <= S_PRESS;
              r_cnt   <= '0;
            end else if (r_cnt == L_GAP) begin
              code       <= r_sr;
              len        <= r_n;
              code_err   <= r_ovf;
              code_valid <= 1'b1;
              r_state    <= S_IDLE;
              r_cnt      <= '0;
              r_sr       <= '0;
              r_n        <= '0;
              r_ovf      <= 1'b0;
            end else if (ms_tick) begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_key_decoder.sv
// Randomized bench for morse_key_decoder against a duration/queue-based reference model.
module tb_morse_key_decoder;

  localparam int DASH = 3;
  localparam int MINP = 1;
  localparam int GAP  = 7;
  localparam int CW   = 4;
  localparam int SAT  = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       ms_tick = 1'b0;
  logic       key = 1'b0;
  logic [4:0] code;
  logic [2:0] len;
  logic       code_valid;
  logic       code_err;

  morse_key_decoder #(.DASH_MS(DASH), .MIN_MS(MINP), .GAP_MS(GAP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ms_tick(ms_tick), .key(key),
    .code(code), .len(len), .code_valid(code_valid), .code_err(code_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_strobe = 0;
  int phase = 0;

  // Reference model: key_s pipeline, press/gap flags, tick count, symbol queue.
  bit   k1, k2, kp;
  bit   in_press, gap_open;
  int   ticks;
  bit   syms[$];
  logic [4:0] exp_code;
  logic [2:0] exp_len;
  logic       exp_err, exp_vld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    k1 = 0; k2 = 0; kp = 0;
    in_press = 0; gap_open = 0; ticks = 0;
    syms.delete();
    exp_code = '0; exp_len = '0; exp_err = 1'b0; exp_vld = 1'b0;
  endtask

  task automatic model_step();
    bit rise, fall;
    logic [4:0] c;
    if (rst) begin
      model_reset();
      return;
    end
    rise = k2 && !kp;
    fall = !k2 && kp;
    exp_vld = 1'b0;
    if (!enable) begin
      in_press = 0; gap_open = 0; ticks = 0;
      syms.delete();
    end else if (in_press) begin
      if (fall) begin
        if (ticks >= MINP) syms.push_back(ticks >= DASH);
        in_press = 0;
        ticks = 0;
        gap_open = (syms.size() > 0);
      end else if (ms_tick && ticks < SAT) begin
        ticks++;
      end
    end else if (gap_open) begin
      if (rise) begin
        in_press = 1; gap_open = 0; ticks = 0;
      end else if (ticks == GAP) begin
        // Only the first five symbols are kept; later ones just flag overflow.
        c = '0;
        for (int i = 0; i < syms.size() && i < 5; i++) c = {c[3:0], syms[i]};
        exp_code = c;
        exp_len  = (syms.size() > 5) ? 3'd5 : 3'(syms.size());
        exp_err  = (syms.size() > 5);
        exp_vld  = 1'b1;
        gap_open = 0; ticks = 0;
        syms.delete();
      end else if (ms_tick) begin
        ticks++;
      end
    end else if (rise) begin
      in_press = 1; ticks = 0;
    end
    kp = k2; k2 = k1; k1 = key;
  endtask

  task automatic cyc();
    ms_tick = (phase == 3);
    phase = (phase + 1) % 4;
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (code_valid) n_strobe++;
    chk("code_valid", 32'(code_valid), 32'(exp_vld));
    chk("code", 32'(code), 32'(exp_code));
    chk("len", 32'(len), 32'(exp_len));
    chk("code_err", 32'(code_err), 32'(exp_err));
  endtask

  task automatic hold(input logic k, input int n);
    key = k;
    for (int i = 0; i < n; i++) cyc();
  endtask

  int s0;

  initial begin
    model_reset();
    rst = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      key = i[0];
      cyc();
    end
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_len", 32'(len), 32'd0);
    rst = 1'b0;
    s0 = n_strobe;
    hold(1'b0, 80);
    chk("idle_no_strobe", n_strobe - s0, 0);

    // Single dash
    s0 = n_strobe;
    hold(1'b1, 20); hold(1'b0, 48);
    chk("s1_code", 32'(code), 32'd1);
    chk("s1_len", 32'(len), 32'd1);
    chk("s1_err", 32'(code_err), 32'd0);
    chk("s1_strobes", n_strobe - s0, 1);

    // "R" = .-.
    s0 = n_strobe;
    hold(1'b1, 6); hold(1'b0, 8);
    hold(1'b1, 16); hold(1'b0, 8);
    hold(1'b1, 6); hold(1'b0, 48);
    chk("r_code", 32'(code), 32'b00010);
    chk("r_len", 32'(len), 32'd3);
    chk("r_strobes", n_strobe - s0, 1);

    // Six dots overflow, then "T"
    for (int i = 0; i < 6; i++) begin
      hold(1'b1, 6); hold(1'b0, 8);
    end
    hold(1'b0, 40);
    chk("ovf_code", 32'(code), 32'd0);
    chk("ovf_len", 32'(len), 32'd5);
    chk("ovf_err", 32'(code_err), 32'd1);
    hold(1'b1, 20); hold(1'b0, 48);
    chk("t_code", 32'(code), 32'd1);
    chk("t_err", 32'(code_err), 32'd0);

    // Zero-tick glitch from idle
    s0 = n_strobe;
    hold(1'b1, 1); hold(1'b0, 48);
    chk("glitch_no_strobe", n_strobe - s0, 0);

    // Sweep second-press start across the gap-expiry cycle
    for (int off = 22; off <= 38; off++) begin
      hold(1'b1, 6); hold(1'b0, off);
      hold(1'b1, 16); hold(1'b0, 48);
    end

    // enable drop during third press with two symbols buffered
    hold(1'b1, 20); hold(1'b0, 48);
    s0 = n_strobe;
    hold(1'b1, 6); hold(1'b0, 8);
    hold(1'b1, 16); hold(1'b0, 8);
    key = 1'b1; hold(1'b1, 6);
    enable = 1'b0;
    hold(1'b1, 6); hold(1'b0, 40);
    chk("en_no_strobe", n_strobe - s0, 0);
    chk("en_code_held", 32'(code), 32'd1);
    chk("en_len_held", 32'(len), 32'd1);
    enable = 1'b1;
    hold(1'b0, 4);
    hold(1'b1, 16); hold(1'b0, 8);
    hold(1'b1, 6); hold(1'b0, 48);
    chk("n_code", 32'(code), 32'b00010);
    chk("n_len", 32'(len), 32'd2);

    // Reset mid-character
    s0 = n_strobe;
    hold(1'b1, 16); hold(1'b0, 8);
    rst = 1'b1; hold(1'b0, 3);
    rst = 1'b0; hold(1'b0, 48);
    chk("rst_mid_no_strobe", n_strobe - s0, 0);
    chk("rst_mid_len", 32'(len), 32'd0);

    // Random characters with occasional enable drops
    for (int c = 0; c < 60; c++) begin
      int nsym;
      nsym = $urandom_range(1, 7);
      for (int s = 0; s < nsym; s++) begin
        hold(1'b1, $urandom_range(1, 30));
        if ($urandom_range(0, 29) == 0) enable = 1'b0;
        hold(1'b0, $urandom_range(1, 34));
        enable = 1'b1;
      end
      hold(1'b0, $urandom_range(20, 45));
    end
    hold(1'b0, 48);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
